// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - writeback control word layout and branch-type encodings
package wb_pkg;

  localparam int WB_REGW  = 0;
  localparam int WB_M2R   = 1;
  localparam int WB_IMM   = 2;
  localparam int WB_FLAGW = 3;
  localparam int WB_BR_LO = 4;
  localparam int WB_BR_HI = 5;

  localparam logic [1:0] BR_NONE   = 2'b00;
  localparam logic [1:0] BR_Z      = 2'b01;
  localparam logic [1:0] BR_N      = 2'b10;
  localparam logic [1:0] BR_ALWAYS = 2'b11;

  // Condition is resolved against the architectural flags held before this instruction.
  function automatic logic br_cond(input logic [1:0] br, input logic n, input logic z);
    case (br)
      BR_Z:      return z;
      BR_N:      return n;
      BR_ALWAYS: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_squash_ctr.sv
// rtl/wb_squash_ctr.sv - down-counter tracking wrong-path instructions left to discard
module wb_squash_ctr (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic [2:0] count,
  output logic       zero
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign zero = (count == 3'd0);

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: register-file write, flags, branch resolve, squash
module wb_stage
  import wb_pkg::*;
#(
  parameter int FLUSH_DEPTH = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] iDMEM,
  input  logic [31:0] iALU,
  input  logic [31:0] iI,
  input  logic [5:0]  iRd,
  input  logic [6:0]  iWB,
  input  logic        iN,
  input  logic        iZ,
  output logic        rf_we,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flag_n,
  output logic        flag_z,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        flush,
  output logic [31:0] retired
);

  logic [2:0]  sq;
  logic        sq_zero;
  logic        active;
  logic        take;
  logic [31:0] wdata;
  logic        wb_unused;

  assign wb_unused = iWB[6];

  // Anything arriving while the squash counter runs is wrong-path and dropped.
  assign active = sq_zero && (iWB != 7'd0);
  assign take   = active && br_cond(iWB[WB_BR_HI:WB_BR_LO], flag_n, flag_z);

  always_comb begin
    wdata = iALU;
    if (iWB[WB_M2R])      wdata = iDMEM;
    else if (iWB[WB_IMM]) wdata = iI;
  end

  wb_squash_ctr u_squash (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (take),
    .load_val (3'(FLUSH_DEPTH)),
    .dec      (!sq_zero),
    .count    (sq),
    .zero     (sq_zero)
  );

  assign flush = !sq_zero;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rf_we     <= 1'b0;
      rf_waddr  <= 6'd0;
      rf_wdata  <= 32'd0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      br_taken  <= 1'b0;
      br_target <= 32'd0;
      retired   <= 32'd0;
    end else begin
      rf_we    <= active && iWB[WB_REGW];
      rf_waddr <= iRd;
      rf_wdata <= wdata;
      br_taken <= take;
      if (take) br_target <= iALU;
      if (active && iWB[WB_FLAGW]) begin
        flag_n <= iN;
        flag_z <= iZ;
      end
      if (active) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] iDMEM = '0, iALU = '0, iI = '0;
  logic [5:0]  iRd = '0;
  logic [6:0]  iWB = '0;
  logic        iN = 1'b0, iZ = 1'b0;
  logic        rf_we, flag_n, flag_z, br_taken, flush;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata, br_target, retired;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  wb_stage #(.FLUSH_DEPTH(3)) dut (
    .clock(clock), .reset_n(reset_n), .iDMEM(iDMEM), .iALU(iALU), .iI(iI),
    .iRd(iRd), .iWB(iWB), .iN(iN), .iZ(iZ), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .flag_n(flag_n), .flag_z(flag_z), .br_taken(br_taken),
    .br_target(br_target), .flush(flush), .retired(retired)
  );

  task automatic apply(input logic [6:0] wb, input logic [31:0] alu, input logic [31:0] dmem,
                       input logic [31:0] imm, input logic [5:0] rd, input logic n, input logic z);
    @(negedge clock);
    iWB = wb; iALU = alu; iDMEM = dmem; iI = imm; iRd = rd; iN = n; iZ = z;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    apply(7'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h3F, 1'b1, 1'b1);
    apply(7'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h3F, 1'b1, 1'b1);
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we got %0h exp 0", rf_we); end
    vectors++; if (rf_waddr !== 6'd0) begin miscompares++; $display("FAIL reset_rf_waddr got %0h exp 0", rf_waddr); end
    vectors++; if (rf_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_rf_wdata got %0h exp 0", rf_wdata); end
    vectors++; if ({flag_n, flag_z} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %0b exp 00", {flag_n, flag_z}); end
    vectors++; if ({br_taken, flush} !== 2'b00) begin miscompares++; $display("FAIL reset_br_flush got %0b exp 00", {br_taken, flush}); end
    vectors++; if (br_target !== 32'd0) begin miscompares++; $display("FAIL reset_br_target got %0h exp 0", br_target); end
    vectors++; if (retired !== 32'd0) begin miscompares++; $display("FAIL reset_retired got %0h exp 0", retired); end
    reset_n = 1'b1;
  endtask

  task automatic test_alu_write;
    apply(7'b0000001, 32'h1234, 32'h0, 32'h0, 6'd5, 1'b0, 1'b0);
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL alu_we got %0h exp 1", rf_we); end
    vectors++; if (rf_waddr !== 6'd5) begin miscompares++; $display("FAIL alu_waddr got %0h exp 5", rf_waddr); end
    vectors++; if (rf_wdata !== 32'h1234) begin miscompares++; $display("FAIL alu_wdata got %0h exp 1234", rf_wdata); end
    vectors++; if (retired !== 32'd1) begin miscompares++; $display("FAIL alu_retired got %0h exp 1", retired); end
  endtask

  task automatic test_select;
    apply(7'b0000011, 32'h1, 32'hDEAD, 32'h7, 6'd6, 1'b0, 1'b0);
    vectors++; if (rf_wdata !== 32'hDEAD) begin miscompares++; $display("FAIL sel_mem got %0h exp dead", rf_wdata); end
    apply(7'b0000101, 32'h1, 32'hDEAD, 32'hFFFF_FFFC, 6'd7, 1'b0, 1'b0);
    vectors++; if (rf_wdata !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL sel_imm got %0h exp fffffffc", rf_wdata); end
    apply(7'b0000111, 32'h1, 32'hAA, 32'hBB, 6'd8, 1'b0, 1'b0);
    vectors++; if (rf_wdata !== 32'hAA) begin miscompares++; $display("FAIL sel_priority got %0h exp aa", rf_wdata); end
    vectors++; if (retired !== 32'd4) begin miscompares++; $display("FAIL sel_retired got %0h exp 4", retired); end
  endtask

  task automatic test_bubble;
    apply(7'b0000000, 32'h5555, 32'h6666, 32'h7777, 6'd9, 1'b1, 1'b1);
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL bubble_we got %0h exp 0", rf_we); end
    vectors++; if (retired !== 32'd4) begin miscompares++; $display("FAIL bubble_retired got %0h exp 4", retired); end
    vectors++; if ({flag_n, flag_z, br_taken} !== 3'b000) begin miscompares++; $display("FAIL bubble_flags_br got %0b exp 000", {flag_n, flag_z, br_taken}); end
  endtask

  task automatic test_branch_squash;
    apply(7'b0001000, 32'h0, 32'h0, 32'h0, 6'd0, 1'b0, 1'b1);
    vectors++; if ({flag_n, flag_z, rf_we} !== 3'b010) begin miscompares++; $display("FAIL flagw_nz_we got %0b exp 010", {flag_n, flag_z, rf_we}); end
    apply(7'b0010000, 32'h40, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0);
    vectors++; if ({br_taken, flush} !== 2'b11) begin miscompares++; $display("FAIL br_taken_flush got %0b exp 11", {br_taken, flush}); end
    vectors++; if (br_target !== 32'h40) begin miscompares++; $display("FAIL br_target got %0h exp 40", br_target); end
    vectors++; if (retired !== 32'd6) begin miscompares++; $display("FAIL br_retired got %0h exp 6", retired); end
    apply(7'b0000001, 32'h11, 32'h0, 32'h0, 6'd7, 1'b0, 1'b0);
    vectors++; if ({rf_we, br_taken, flush} !== 3'b001) begin miscompares++; $display("FAIL sq1 got %0b exp 001", {rf_we, br_taken, flush}); end
    apply(7'b0110001, 32'h22, 32'h0, 32'h0, 6'd7, 1'b0, 1'b0);
    vectors++; if ({rf_we, br_taken, flush} !== 3'b001) begin miscompares++; $display("FAIL sq2_branch got %0b exp 001", {rf_we, br_taken, flush}); end
    vectors++; if (br_target !== 32'h40) begin miscompares++; $display("FAIL sq2_target got %0h exp 40", br_target); end
    apply(7'b0000001, 32'h33, 32'h0, 32'h0, 6'd7, 1'b0, 1'b0);
    vectors++; if ({rf_we, br_taken, flush} !== 3'b000) begin miscompares++; $display("FAIL sq3 got %0b exp 000", {rf_we, br_taken, flush}); end
    vectors++; if (retired !== 32'd6) begin miscompares++; $display("FAIL sq_retired got %0h exp 6", retired); end
    apply(7'b0000001, 32'h99, 32'h0, 32'h0, 6'd9, 1'b0, 1'b0);
    vectors++; if ({rf_we, flush} !== 2'b10) begin miscompares++; $display("FAIL post_sq_we_flush got %0b exp 10", {rf_we, flush}); end
    vectors++; if (rf_wdata !== 32'h99) begin miscompares++; $display("FAIL post_sq_wdata got %0h exp 99", rf_wdata); end
    vectors++; if (retired !== 32'd7) begin miscompares++; $display("FAIL post_sq_retired got %0h exp 7", retired); end
  endtask

  task automatic test_old_flags;
    apply(7'b0001000, 32'h0, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0);
    vectors++; if ({flag_n, flag_z} !== 2'b00) begin miscompares++; $display("FAIL clear_flags got %0b exp 00", {flag_n, flag_z}); end
    apply(7'b0011000, 32'h80, 32'h0, 32'h0, 6'd0, 1'b0, 1'b1);
    vectors++; if ({br_taken, flush, flag_z} !== 3'b001) begin miscompares++; $display("FAIL oldz_br got %0b exp 001", {br_taken, flush, flag_z}); end
    apply(7'b0101000, 32'h80, 32'h0, 32'h0, 6'd0, 1'b1, 1'b1);
    vectors++; if ({br_taken, flag_n} !== 2'b01) begin miscompares++; $display("FAIL oldn_br got %0b exp 01", {br_taken, flag_n}); end
    vectors++; if (retired !== 32'd10) begin miscompares++; $display("FAIL oldflag_retired got %0h exp a", retired); end
  endtask

  task automatic test_link_and_reset_mid_squash;
    apply(7'b0110001, 32'h100, 32'h0, 32'h0, 6'd31, 1'b0, 1'b0);
    vectors++; if ({rf_we, br_taken, flush} !== 3'b111) begin miscompares++; $display("FAIL link_we_br got %0b exp 111", {rf_we, br_taken, flush}); end
    vectors++; if ({rf_waddr, rf_wdata, br_target} !== {6'd31, 32'h100, 32'h100}) begin miscompares++; $display("FAIL link_data got %0h/%0h/%0h exp 1f/100/100", rf_waddr, rf_wdata, br_target); end
    apply(7'b0000001, 32'h1, 32'h0, 32'h0, 6'd1, 1'b0, 1'b0);
    vectors++; if ({rf_we, flush} !== 2'b01) begin miscompares++; $display("FAIL link_sq1 got %0b exp 01", {rf_we, flush}); end
    reset_n = 1'b0;
    apply(7'b0000001, 32'h2, 32'h0, 32'h0, 6'd2, 1'b0, 1'b0);
    reset_n = 1'b1;
    vectors++; if ({rf_we, flush, br_taken, flag_n, flag_z} !== 5'b0) begin miscompares++; $display("FAIL midrst_ctl got %0b exp 00000", {rf_we, flush, br_taken, flag_n, flag_z}); end
    vectors++; if ({rf_waddr, rf_wdata, br_target, retired} !== '0) begin miscompares++; $display("FAIL midrst_data got %0h/%0h/%0h/%0h exp 0", rf_waddr, rf_wdata, br_target, retired); end
    apply(7'b0000001, 32'h55, 32'h0, 32'h0, 6'd3, 1'b0, 1'b0);
    vectors++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 6'd3, 32'h55}) begin miscompares++; $display("FAIL postrst_write got %0h/%0h/%0h exp 1/3/55", rf_we, rf_waddr, rf_wdata); end
    vectors++; if (retired !== 32'd1) begin miscompares++; $display("FAIL postrst_retired got %0h exp 1", retired); end
  endtask

  task automatic test_retired_wrap;
    apply(7'b0000000, 32'h0, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0);
    @(negedge clock);
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    apply(7'b0000000, 32'h0, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0);
    vectors++; if (retired !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_preload got %0h exp ffffffff", retired); end
    apply(7'b0000001, 32'h7, 32'h0, 32'h0, 6'd4, 1'b0, 1'b0);
    vectors++; if (retired !== 32'd0) begin miscompares++; $display("FAIL wrap_retired got %0h exp 0", retired); end
    apply(7'b0000000, 32'h7, 32'h0, 32'h0, 6'd4, 1'b0, 1'b0);
    vectors++; if (retired !== 32'd0) begin miscompares++; $display("FAIL wrap_bubble got %0h exp 0", retired); end
  endtask

  initial begin
    test_reset;
    test_alu_write;
    test_select;
    test_bubble;
    test_branch_squash;
    test_old_flags;
    test_link_and_reset_mid_squash;
    test_retired_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
